// File: rtl/peripheral_register_arbiter_pkg.sv
// Shared types and helpers for the two-port peripheral register arbiter.
package peripheral_register_arbiter_pkg;

    localparam int unsigned NUM_PORTS  = 2;
    // Command fields are sized for the widest supported bank; narrower
    // instances zero-extend on capture and truncate on use.
    localparam int unsigned CMD_ADDR_W = 16;
    localparam int unsigned CMD_DATA_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    typedef struct packed {
        logic                  port;
        logic                  write;
        logic [CMD_ADDR_W-1:0] addr;
        logic [CMD_DATA_W-1:0] wdata;
        logic                  in_range;
    } cmd_t;

    function automatic int unsigned addr_width(input int unsigned regs);
        int unsigned w;
        if (regs <= 1) begin
            w = 1;
        end else begin
            w = 32'($clog2(regs));
        end
        return w;
    endfunction

endpackage

// File: rtl/peripheral_register_arbiter_rr_arbiter_2.sv
// Combinational two-way round-robin grant; the pointer lives in the parent.
module rr_arbiter_2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    input  logic       enable,
    output logic [1:0] grant_c
);

    always_comb begin
        grant_c = 2'b00;
        if (enable) begin
            case (valid)
                2'b01:   grant_c = 2'b01;
                2'b10:   grant_c = 2'b10;
                2'b11:   grant_c = last_grant ? 2'b01 : 2'b10;
                default: grant_c = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/peripheral_register_arbiter.sv
// Two-port round-robin front end to a peripheral register bank: one access
// at a time, one-hot strobes in ACCESS, one-cycle response pulse in RESP.
module peripheral_register_arbiter
    import peripheral_register_arbiter_pkg::*;
#(
    parameter int unsigned BUSWIDTH     = 32,
    parameter int unsigned REGS         = 4,
    parameter int unsigned ADDRESSWIDTH = addr_width(REGS)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [1:0]                 req_valid,
    output logic [1:0]                 req_ready,
    input  logic [1:0]                 req_write,
    input  logic [2*ADDRESSWIDTH-1:0]  req_addr,
    input  logic [2*BUSWIDTH-1:0]      req_wdata,
    output logic [1:0]                 rsp_valid,
    output logic                       rsp_error,
    output logic [BUSWIDTH-1:0]        rsp_rdata,
    output logic [BUSWIDTH-1:0]        reg_data_in,
    output logic [REGS-1:0]            reg_write_en,
    output logic [REGS-1:0]            reg_read_en,
    input  logic [REGS*BUSWIDTH-1:0]   reg_data_out
);

    state_e                state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    cmd_t                  cmd_q, cmd_d;
    logic [1:0]            rsp_valid_q, rsp_valid_d;
    logic                  rsp_error_q, rsp_error_d;
    logic [BUSWIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;

    logic                  arb_en_c;
    logic [1:0]            grant_c;
    logic                  sel_port_c;
    logic                  sel_write_c;
    logic [ADDRESSWIDTH-1:0] sel_addr_c;
    logic [BUSWIDTH-1:0]   sel_wdata_c;
    logic                  sel_in_range_c;
    logic [REGS-1:0]       cur_onehot_c;
    logic [BUSWIDTH-1:0]   cur_rdata_c;

    // Gating with reset keeps req_ready low while reset is asserted.
    assign arb_en_c = reset && (state_q == ST_IDLE);

    rr_arbiter_2 u_arb (
        .valid      (req_valid),
        .last_grant (last_grant_q),
        .enable     (arb_en_c),
        .grant_c    (grant_c)
    );

    assign req_ready = grant_c;

    assign sel_port_c     = grant_c[1];
    assign sel_write_c    = req_write[sel_port_c];
    assign sel_addr_c     = sel_port_c ? req_addr[2*ADDRESSWIDTH-1:ADDRESSWIDTH]
                                       : req_addr[ADDRESSWIDTH-1:0];
    assign sel_wdata_c    = sel_port_c ? req_wdata[2*BUSWIDTH-1:BUSWIDTH]
                                       : req_wdata[BUSWIDTH-1:0];
    assign sel_in_range_c = (32'(sel_addr_c) < 32'(REGS));

    // Decode of the latched address; out-of-range indices match nothing.
    always_comb begin
        cur_onehot_c = '0;
        cur_rdata_c  = '0;
        for (int unsigned i = 0; i < REGS; i++) begin
            if (cmd_q.addr == CMD_ADDR_W'(i)) begin
                cur_onehot_c[i] = 1'b1;
                cur_rdata_c     = reg_data_out[i*BUSWIDTH +: BUSWIDTH];
            end
        end
    end

    // Bank-side strobes are a pure decode of ACCESS so async reset kills them at once.
    always_comb begin
        reg_write_en = '0;
        reg_read_en  = '0;
        reg_data_in  = '0;
        if ((state_q == ST_ACCESS) && cmd_q.in_range) begin
            if (cmd_q.write) begin
                reg_write_en = cur_onehot_c;
                reg_data_in  = BUSWIDTH'(cmd_q.wdata);
            end else begin
                reg_read_en  = cur_onehot_c;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cmd_d        = cmd_q;
        rsp_valid_d  = 2'b00;
        rsp_error_d  = 1'b0;
        rsp_rdata_d  = '0;

        case (state_q)
            ST_IDLE: begin
                if (|grant_c) begin
                    cmd_d.port     = sel_port_c;
                    cmd_d.write    = sel_write_c;
                    cmd_d.addr     = CMD_ADDR_W'(sel_addr_c);
                    cmd_d.wdata    = CMD_DATA_W'(sel_wdata_c);
                    cmd_d.in_range = sel_in_range_c;
                    last_grant_d   = sel_port_c;
                    state_d        = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // Read data is sampled on the same edge the read strobe retires.
                rsp_valid_d[cmd_q.port] = 1'b1;
                rsp_error_d             = !cmd_q.in_range;
                if (!cmd_q.write && cmd_q.in_range) begin
                    rsp_rdata_d = cur_rdata_c;
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            cmd_q        <= '0;
            rsp_valid_q  <= 2'b00;
            rsp_error_q  <= 1'b0;
            rsp_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cmd_q        <= cmd_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_error_q  <= rsp_error_d;
            rsp_rdata_q  <= rsp_rdata_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_error = rsp_error_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: doc/peripheral_register_arbiter.md
Name: peripheral_register_arbiter

Overview:
- Shares one peripheral register bank between two requesters, ranked equally: port 0 (host bus) and port 1 (debug/test access).
- Arbitrates round-robin and runs one register access at a time.
- Decodes the address into one-hot write/read strobes for the register bank, drives the bank's data_in, and returns read data or a write ack with an error flag.
- Sits between the bus-facing bridges and the register side of the peripheral register interface.

Parameters:
- BUSWIDTH, 32, register data width.
- REGS, 4, number of implemented registers.
- ADDRESSWIDTH, max(1,$clog2(REGS)), requester address width.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  2  per-port request valid; bit i = port i.
- req_ready  output  2  per-port accept; valid&ready = handshake.
- req_write  input  2  1 = write, 0 = read.
- req_addr  input  2*ADDRESSWIDTH  per-port register index; port i at [i*AW +: AW].
- req_wdata  input  2*BUSWIDTH  per-port write data.
- rsp_valid  output  2  one-cycle response pulse to the originating port.
- rsp_error  output  1  qualified by rsp_valid; address >= REGS.
- rsp_rdata  output  BUSWIDTH  read data; qualified by rsp_valid and read.
- reg_data_in  output  BUSWIDTH  write data to the register bank.
- reg_write_en  output  REGS  one-hot write strobe.
- reg_read_en  output  REGS  one-hot read strobe (for clear-on-read side effects).
- reg_data_out  input  REGS*BUSWIDTH  register read values; reg i at [i*BW +: BW].

Behaviour:
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- On reset assertion, outputs go to 0 immediately: req_ready, rsp_valid, rsp_error, rsp_rdata, reg_data_in, reg_write_en, reg_read_en.
  - last_grant resets to 1, so port 0 wins the first tie.
- IDLE:
  - req_ready is combinational, and only in IDLE.
  - If exactly one port is valid, that port is ready.
  - If both are valid, the port != last_grant is ready.
  - If neither is valid, stay in IDLE.
- On handshake (cycle T):
  - Latch port, write, addr, wdata and in_range = (addr < REGS).
  - Update last_grant to the granted port; go to ACCESS.
- ACCESS (cycle T+1):
  - If in_range: drive reg_data_in = wdata for writes; assert exactly one bit, reg_write_en[addr] or reg_read_en[addr], for this cycle only.
  - At end of T+1, capture reg_data_out[addr] into rsp_rdata for reads, so read-side effects and the captured value fall on the same edge.
  - If out of range: no strobe; rsp_rdata captured as 0.
  - Go to RESP.
- RESP (cycle T+2):
  - rsp_valid[port] = 1 for one cycle; rsp_error = !in_range.
  - Writes get an ack with rsp_rdata = 0.
  - Return to IDLE.
- Latency: accept-to-response 2 cycles. Max throughput is one access per 3 cycles; the next accept is earliest at T+3.
- There is no response backpressure; a requester must be able to take rsp_valid at any time.
- Requesters hold req_* stable while valid && !ready. A valid dropped before accept is legal and never executed.
- Strobes and reg_data_in are 0 outside ACCESS.
- Under continuous contention, grants alternate strictly 0,1,0,1. Neither port is starved beyond one access.
- Reset mid-access: the transaction is dropped with no strobe or response completing; after deassert, IDLE with last_grant = 1.
- REGS not a power of 2: addresses REGS..2^AW-1 give error. REGS = 1 uses AW = 1.

Decomposition:
- Package peripheral_register_arbiter_pkg:
  - state enum (IDLE, ACCESS, RESP);
  - NUM_PORTS = 2;
  - packed command struct (port, write, addr, wdata, in_range);
  - function deriving ADDRESSWIDTH.
- Sub-module rr_arbiter_2: combinational 2-way round-robin grant from valid, last_grant and an enable, producing one-hot grant. Its pointer update stays in the parent.

Test Plan:
- Port 0 writes addr 2, data 0xDEADBEEF -> reg_write_en = 4'b0100 at T+1 only; reg_data_in = 0xDEADBEEF; rsp_valid = 2'b01 at T+2; rsp_error = 0.
- Port 1 reads addr 3 with reg_data_out[3] = 0x12345678 -> reg_read_en = 4'b1000 at T+1; rsp_valid = 2'b10 and rsp_rdata = 0x12345678 at T+2.
- Both ports valid for 4 consecutive accesses after reset -> grant order 0,1,0,1; accepts exactly 3 cycles apart.
- REGS = 3, port 0 reads addr 3 -> no strobe; rsp_error = 1; rsp_rdata = 0 at T+2.
- Reset asserted during ACCESS -> strobes drop to 0 asynchronously, no rsp_valid. After release, a simultaneous request from both ports is granted to port 0.
- Port 1 asserts valid while port 0 is in ACCESS, then withdraws before IDLE -> never readied, no strobe, no response for port 1.
